// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: opcodes, ALU codes,
// writeback source encodings and FSM state encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_L     = 7'b0000011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] RFWD_ALU   = 3'b000;
  localparam logic [2:0] RFWD_LOAD  = 3'b001;
  localparam logic [2:0] RFWD_LUI   = 3'b010;
  localparam logic [2:0] RFWD_AUIPC = 3'b011;
  localparam logic [2:0] RFWD_PC4   = 3'b100;

  // Legacy state encodings; the enum below is pinned to these values.
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_R_EX   = 4'd2;
  localparam logic [3:0] ST_I_EX   = 4'd3;
  localparam logic [3:0] ST_B_EX   = 4'd4;
  localparam logic [3:0] ST_LU_EX  = 4'd5;
  localparam logic [3:0] ST_AU_EX  = 4'd6;
  localparam logic [3:0] ST_J_EX   = 4'd7;
  localparam logic [3:0] ST_JL_EX  = 4'd8;
  localparam logic [3:0] ST_S_EX   = 4'd9;
  localparam logic [3:0] ST_S_MEM  = 4'd10;
  localparam logic [3:0] ST_L_EX   = 4'd11;
  localparam logic [3:0] ST_L_MEM  = 4'd12;
  localparam logic [3:0] ST_L_WB   = 4'd13;
  localparam logic [3:0] ST_TRAP   = 4'd14;

  typedef enum logic [3:0] {
    FETCH  = ST_FETCH,
    DECODE = ST_DECODE,
    R_EX   = ST_R_EX,
    I_EX   = ST_I_EX,
    B_EX   = ST_B_EX,
    LU_EX  = ST_LU_EX,
    AU_EX  = ST_AU_EX,
    J_EX   = ST_J_EX,
    JL_EX  = ST_JL_EX,
    S_EX   = ST_S_EX,
    S_MEM  = ST_S_MEM,
    L_EX   = ST_L_EX,
    L_MEM  = ST_L_MEM,
    L_WB   = ST_L_WB,
    TRAP   = ST_TRAP
  } state_e;

  // Only shifts carry an arithmetic/logical select in bit 30 for I-type.
  function automatic logic [3:0] alu_i_ctrl(input logic b30, input logic [2:0] f3);
    return (f3 == 3'b101) ? {b30, 3'b101} : {1'b0, f3};
  endfunction

endpackage

// File: rtl/cu_wait_counter.sv
// Bus wait-state counter: counts consecutive not-ready cycles of one access and
// flags the cycle in which the WAIT_MAX-th wait cycle is being spent.
module cu_wait_counter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = expired_o ? '0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rv32i_mc_control_hs.sv
// Multi-cycle RV32I control unit with ready-handshaked instruction/data buses,
// wait-state timeout with refetch, and retired-instruction counter.
// Optional macro CU_ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP (else NOP).
module rv32i_mc_control_hs
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IR_En,
  output logic             PC_En,
  output logic             regFileWe,
  output logic [3:0]       aluControl,
  output logic             aluSrcMuxSel,
  output logic             busReq,
  output logic             busWe,
  output logic [2:0]       RFWDSrcMuxSel,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic [2:0]       L_mode,
  output logic [2:0]       S_mode,
  output logic             bus_timeout,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             wait_st, ready_sel, expired, timeout;
  logic [2:0]       funct3;
  logic             unused_instr;

  assign funct3       = instrCode[14:12];
  assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign wait_st   = (state_q == FETCH) || (state_q == S_MEM) || (state_q == L_MEM);
  assign ready_sel = (state_q == FETCH) ? imem_ready : dmem_ready;
  assign timeout   = wait_st && !ready_sel && expired;

  // Counter is held clear outside bus states, so every access starts from zero.
  cu_wait_counter #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (!wait_st || ready_sel),
    .en_i      (wait_st && !ready_sel),
    .expired_o (expired)
  );

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    IR_En         = 1'b0;
    PC_En         = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    L_mode        = '0;
    S_mode        = '0;
    bus_timeout   = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IR_En   = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          bus_timeout = 1'b1;
        end
      end
      DECODE: begin
        case (instrCode[6:0])
          OP_R:     state_d = R_EX;
          OP_I:     state_d = I_EX;
          OP_B:     state_d = B_EX;
          OP_LUI:   state_d = LU_EX;
          OP_AUIPC: state_d = AU_EX;
          OP_JAL:   state_d = J_EX;
          OP_JALR:  state_d = JL_EX;
          OP_S:     state_d = S_EX;
          OP_L:     state_d = L_EX;
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_d = TRAP;
`else
            PC_En   = 1'b1;
            state_d = FETCH;
`endif
          end
        endcase
      end
      R_EX: begin
        regFileWe  = 1'b1;
        aluControl = {instrCode[30], funct3};
        PC_En      = 1'b1;
        state_d    = FETCH;
      end
      I_EX: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        aluControl   = alu_i_ctrl(instrCode[30], funct3);
        PC_En        = 1'b1;
        state_d      = FETCH;
      end
      B_EX: begin
        branch     = 1'b1;
        aluControl = {instrCode[30], funct3};
        PC_En      = 1'b1;
        state_d    = FETCH;
      end
      LU_EX: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_LUI;
        PC_En         = 1'b1;
        state_d       = FETCH;
      end
      AU_EX: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_AUIPC;
        PC_En         = 1'b1;
        state_d       = FETCH;
      end
      J_EX: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
        PC_En         = 1'b1;
        state_d       = FETCH;
      end
      JL_EX: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
        jalr          = 1'b1;
        PC_En         = 1'b1;
        state_d       = FETCH;
      end
      S_EX: begin
        aluSrcMuxSel = 1'b1;
        S_mode       = funct3;
        state_d      = S_MEM;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busReq       = 1'b1;
        busWe        = 1'b1;
        S_mode       = funct3;
        if (dmem_ready) begin
          PC_En   = 1'b1;
          state_d = FETCH;
        end else if (timeout) begin
          bus_timeout = 1'b1;
          state_d     = FETCH;
        end
      end
      L_EX: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
        L_mode        = funct3;
        state_d       = L_MEM;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
        L_mode        = funct3;
        busReq        = 1'b1;
        if (dmem_ready) begin
          state_d = L_WB;
        end else if (timeout) begin
          bus_timeout = 1'b1;
          state_d     = FETCH;
        end
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
        L_mode        = funct3;
        PC_En         = 1'b1;
        state_d       = FETCH;
      end
`ifdef CU_ILLEGAL_TRAP_EN
      TRAP: begin
        illegal = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign instret_d = PC_En ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_rv32i_mc_control_hs.sv
// Scoreboard bench: the driver queues hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_rv32i_mc_control_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        imem_ready, dmem_ready;
  logic        imem_req, IR_En, PC_En, regFileWe, aluSrcMuxSel, busReq, busWe;
  logic        branch, jal, jalr, bus_timeout, illegal;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel, L_mode, S_mode;
  logic [31:0] instret;

  always #5 clk = ~clk;

  rv32i_mc_control_hs #(.WAIT_MAX(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .IR_En(IR_En), .PC_En(PC_En), .regFileWe(regFileWe),
    .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel), .busReq(busReq),
    .busWe(busWe), .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal),
    .jalr(jalr), .L_mode(L_mode), .S_mode(S_mode), .bus_timeout(bus_timeout),
    .illegal(illegal), .instret(instret)
  );

  typedef struct {
    string       nm;
    logic [24:0] v;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_instret = '0;

  // Field order: imem_req IR_En PC_En we alu[4] src busReq busWe rfwd[3] br jal jalr L[3] S[3] to ill
  function automatic logic [24:0] E(input logic im, ie, pe, we, input logic [3:0] alu,
                                    input logic src, breq, bwe, input logic [2:0] rf,
                                    input logic b, j, jr, input logic [2:0] lm, sm,
                                    input logic to, il);
    return {im, ie, pe, we, alu, src, breq, bwe, rf, b, j, jr, lm, sm, to, il};
  endfunction

  task automatic step(input string nm, input logic [31:0] ins, input logic ir, dr, rst,
                      input logic [24:0] ev);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    instrCode  = ins;
    imem_ready = ir;
    dmem_ready = dr;
    if (rst) exp_instret = '0;
    e.nm  = nm;
    e.v   = ev;
    e.cnt = exp_instret;
    sb.push_back(e);
    if (ev[22]) exp_instret = exp_instret + 32'd1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [24:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {imem_req, IR_En, PC_En, regFileWe, aluControl, aluSrcMuxSel, busReq, busWe,
               RFWDSrcMuxSel, branch, jal, jalr, L_mode, S_mode, bus_timeout, illegal};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s outputs got %07h expected %07h", e.nm, act, e.v);
        end
        checks++;
        if (instret !== e.cnt) begin
          errors++;
          $display("FAIL %s instret got %0d expected %0d", e.nm, instret, e.cnt);
        end
      end
    end
  end

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_SLLI  = 32'h40311093;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_LW    = 32'h0040A183;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  initial begin : driver
    logic [24:0] F0, F1, D0, LEX, LMEM, LWB, SEX, SMEM;
    F0   = E(1,0,0,0,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0);
    F1   = E(1,1,0,0,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0);
    D0   = '0;
    LEX  = E(0,0,0,0,4'h0,1,0,0,3'd1,0,0,0,3'd2,3'd0,0,0);
    LMEM = E(0,0,0,0,4'h0,1,1,0,3'd1,0,0,0,3'd2,3'd0,0,0);
    LWB  = E(0,0,1,1,4'h0,1,0,0,3'd1,0,0,0,3'd2,3'd0,0,0);
    SEX  = E(0,0,0,0,4'h0,1,0,0,3'd0,0,0,0,3'd0,3'd2,0,0);
    SMEM = E(0,0,0,0,4'h0,1,1,1,3'd0,0,0,0,3'd0,3'd2,0,0);

    reset = 1'b1; instrCode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    step("reset", '0, 0, 0, 1, F0);
    step("fetch_wait", I_ADD, 0, 0, 0, F0);

    step("add_f", I_ADD, 1, 0, 0, F1);
    step("add_d", I_ADD, 0, 0, 0, D0);
    step("add_ex", I_ADD, 0, 0, 0, E(0,0,1,1,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));

    step("sub_f", I_SUB, 1, 0, 0, F1);
    step("sub_d", I_SUB, 0, 0, 0, D0);
    step("sub_ex", I_SUB, 0, 0, 0, E(0,0,1,1,4'h8,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));

    step("srai_f", I_SRAI, 1, 0, 0, F1);
    step("srai_d", I_SRAI, 0, 0, 0, D0);
    step("srai_ex", I_SRAI, 0, 0, 0, E(0,0,1,1,4'hD,1,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));

    step("slli_f", I_SLLI, 1, 0, 0, F1);
    step("slli_d", I_SLLI, 0, 0, 0, D0);
    step("slli_ex", I_SLLI, 0, 0, 0, E(0,0,1,1,4'h1,1,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));

    step("bne_f", I_BNE, 1, 0, 0, F1);
    step("bne_d", I_BNE, 0, 0, 0, D0);
    step("bne_ex", I_BNE, 0, 0, 0, E(0,0,1,0,4'h1,0,0,0,3'd0,1,0,0,3'd0,3'd0,0,0));

    step("lui_f", I_LUI, 1, 0, 0, F1);
    step("lui_d", I_LUI, 0, 0, 0, D0);
    step("lui_ex", I_LUI, 0, 0, 0, E(0,0,1,1,4'h0,0,0,0,3'd2,0,0,0,3'd0,3'd0,0,0));

    step("auipc_f", I_AUIPC, 1, 0, 0, F1);
    step("auipc_d", I_AUIPC, 0, 0, 0, D0);
    step("auipc_ex", I_AUIPC, 0, 0, 0, E(0,0,1,1,4'h0,0,0,0,3'd3,0,0,0,3'd0,3'd0,0,0));

    step("jal_f", I_JAL, 1, 0, 0, F1);
    step("jal_d", I_JAL, 0, 0, 0, D0);
    step("jal_ex", I_JAL, 0, 0, 0, E(0,0,1,1,4'h0,0,0,0,3'd4,0,1,0,3'd0,3'd0,0,0));

    step("jalr_f", I_JALR, 1, 0, 0, F1);
    step("jalr_d", I_JALR, 0, 0, 0, D0);
    step("jalr_ex", I_JALR, 0, 0, 0, E(0,0,1,1,4'h0,0,0,0,3'd4,0,1,1,3'd0,3'd0,0,0));

    // Load with 3 wait cycles; ready lands on the 4th L_MEM cycle (WAIT_MAX boundary).
    step("lw_f", I_LW, 1, 0, 0, F1);
    step("lw_d", I_LW, 0, 0, 0, D0);
    step("lw_ex", I_LW, 0, 0, 0, LEX);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", I_LW, 0, 0, 0, LMEM);
    step("lw_mem_rdy", I_LW, 0, 1, 0, LMEM);
    step("lw_wb", I_LW, 0, 0, 0, LWB);

    // Store never acknowledged: abandoned on the 4th wait cycle, then retried.
    step("sw_f", I_SW, 1, 0, 0, F1);
    step("sw_d", I_SW, 0, 0, 0, D0);
    step("sw_ex", I_SW, 0, 0, 0, SEX);
    for (int i = 0; i < 3; i++) step("sw_mem_wait", I_SW, 0, 0, 0, SMEM);
    step("sw_timeout", I_SW, 0, 0, 0, SMEM | E(0,0,0,0,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,1,0));
    step("sw_refetch", I_SW, 1, 0, 0, F1);
    step("sw_d2", I_SW, 0, 0, 0, D0);
    step("sw_ex2", I_SW, 0, 0, 0, SEX);
    step("sw_mem_rdy", I_SW, 0, 1, 0, SMEM | E(0,0,1,0,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));

    step("bad_f", I_BAD, 1, 0, 0, F1);
`ifdef CU_ILLEGAL_TRAP_EN
    step("bad_d", I_BAD, 0, 0, 0, D0);
    for (int i = 0; i < 10; i++)
      step("trap_hold", (i % 2 == 0) ? I_ADD : I_BAD, i[0], ~i[0], 0,
           E(0,0,0,0,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,1));
    step("trap_reset", I_ADD, 0, 0, 1, F0);
`else
    step("bad_d_nop", I_BAD, 0, 0, 0, E(0,0,1,0,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));
`endif

    // Reset in the middle of a load access.
    step("lw2_f", I_LW, 1, 0, 0, F1);
    step("lw2_d", I_LW, 0, 0, 0, D0);
    step("lw2_ex", I_LW, 0, 0, 0, LEX);
    step("lw2_mem", I_LW, 0, 0, 0, LMEM);
    step("lw2_reset", I_LW, 0, 1, 1, F0);
    step("post_f", I_ADD, 1, 0, 0, F1);
    step("post_d", I_ADD, 0, 0, 0, D0);
    step("post_ex", I_ADD, 0, 0, 0, E(0,0,1,1,4'h0,0,0,0,3'd0,0,0,0,3'd0,3'd0,0,0));
    step("final", I_ADD, 0, 0, 0, F0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain scoreboard left %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_control_hs.md
# rv32i_mc_control_hs

Multi-cycle RV32I control unit with ready-handshaked instruction and data buses, a per-access wait-state timeout with retry, and a retired-instruction counter. It sits between the multi-cycle datapath (PC, IR, register file, ALU, LSU) and the instruction and data memories. It replaces fixed one-cycle memory timing with variable-latency bus access.

## Interface
- WAIT_MAX, 15: maximum cycles a bus request waits for ready before it is abandoned; legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- instrCode  in  32  current IR contents; valid from DECODE onward.
- imem_ready  in  1  instruction bus completes the access this cycle.
- dmem_ready  in  1  data bus completes the access this cycle.
- imem_req  out  1  instruction fetch request.
- IR_En  out  1  load IR with fetched word.
- PC_En  out  1  commit next PC.
- regFileWe  out  1  register file write enable.
- aluControl  out  4  ALU operation.
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
- busReq  out  1  data bus request.
- busWe  out  1  data bus write; only meaningful while busReq = 1.
- RFWDSrcMuxSel  out  3  writeback source: 000 ALU, 001 load, 010 LUI imm, 011 AUIPC, 100 PC+4.
- branch, jal, jalr  out  1 each  next-PC select.
- L_mode, S_mode  out  3  instrCode[14:12].
- bus_timeout  out  1  one-cycle pulse when a request is abandoned.
- illegal  out  1  illegal-opcode flag (see Configuration).
- instret  out  CNT_W  retired-instruction count.

## Operation
- States:
  - FETCH, DECODE.
  - R_EX, I_EX, B_EX, LU_EX, AU_EX, J_EX, JL_EX.
  - S_EX, S_MEM, L_EX, L_MEM, L_WB.
  - TRAP (only when the macro is defined).
- FETCH:
  - Outputs: imem_req = 1.
  - On imem_ready: IR_En = 1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE, by opcode:
  - 0110011 → R_EX; 0010011 → I_EX; 1100011 → B_EX.
  - 0110111 → LU_EX; 0010111 → AU_EX.
  - 1101111 → J_EX; 1100111 → JL_EX.
  - 0100011 → S_EX; 0000011 → L_EX.
  - Any other opcode: see Configuration.
- Single-cycle execute states (R/I/B/LU/AU/J/JL_EX) → FETCH. Signals per state:
  - R_EX: regFileWe.
  - I_EX: regFileWe, aluSrcMuxSel.
  - B_EX: branch.
  - LU_EX: regFileWe, RFWDSrcMuxSel = 010.
  - AU_EX: regFileWe, RFWDSrcMuxSel = 011.
  - J_EX: regFileWe, RFWDSrcMuxSel = 100, jal.
  - JL_EX: regFileWe, RFWDSrcMuxSel = 100, jal, jalr.
- Store path:
  - S_EX: aluSrcMuxSel = 1; → S_MEM.
  - S_MEM: busReq = busWe = aluSrcMuxSel = 1; on dmem_ready → FETCH.
- Load path:
  - L_EX: aluSrcMuxSel = 1, RFWDSrcMuxSel = 001; → L_MEM.
  - L_MEM: same signals plus busReq = 1; on dmem_ready → L_WB.
  - L_WB: regFileWe = 1, with L_EX signals; → FETCH.
- PC_En and retirement:
  - PC_En = 1 in each single-cycle execute state, in S_MEM when dmem_ready = 1, and in L_WB.
  - instret increments by 1 on every PC_En and wraps modulo 2^CNT_W.
- aluControl:
  - R_EX and B_EX: {instrCode[30], instrCode[14:12]}.
  - I_EX: {instrCode[30], 101} when funct3 = 101; otherwise {0, funct3}.
  - All other states: ADD (0000).
- Timeout and retry:
  - A wait counter clears on entry to FETCH, S_MEM or L_MEM and increments each cycle ready is low.
  - If the counter reaches WAIT_MAX with ready still low: pulse bus_timeout, go to FETCH without PC_En. The same PC is therefore refetched (retry).
  - If ready arrives in the same cycle the counter hits WAIT_MAX, ready wins and no timeout occurs.
- All outputs not listed for a state are 0.

## Timing
- Reset: state = FETCH, wait counter = 0, instret = 0, illegal = 0, bus_timeout = 0. Every combinational output takes its FETCH value: imem_req = 1, all others 0.
- Reset asserted mid-instruction abandons it immediately; no PC_En is issued.
- Minimum latency with zero wait states:
  - R/I/B/LU/AU/J/JL: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each cycle ready is low adds one cycle to the access.
- Outputs are combinational from state, instrCode and the ready inputs. The ready inputs are sampled at the rising clock edge.

## Configuration
- CU_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE → TRAP.
  - TRAP holds illegal = 1 with all other outputs 0, and is left only by reset.
- CU_ILLEGAL_TRAP_EN undefined:
  - An unknown opcode retires as a NOP: PC_En = 1 in DECODE, then → FETCH.
  - illegal is tied to 0.

## Structure
- Package rv_ctrl_pkg holds the opcode constants, the ALU codes (ADD = 4'b0000), the state_e enum and the RFWD source encodings.
- One sub-module, cu_wait_counter: clear/enable inputs, parameter WAIT_MAX, output expired.

## Test plan
- ADD x3,x1,x2 (0x002081B3), ready always high → FETCH, DECODE, R_EX. regFileWe = 1 and aluControl = 0000 in cycle 3; instret = 1.
- LW with dmem_ready delayed 3 cycles → L_MEM lasts 4 cycles, then L_WB with regFileWe = 1, RFWDSrcMuxSel = 001; PC_En exactly once.
- SW with WAIT_MAX = 4 and dmem_ready never asserted → bus_timeout pulses after 4 wait cycles; next state FETCH; no PC_En; instret unchanged.
- SRAI (funct3 = 101, bit30 = 1) → aluControl = 1101. SLLI with bit30 = 1 → aluControl = 0001.
- Opcode 0x7F → with the macro: illegal = 1, held in TRAP across 10 cycles. Without the macro: PC_En in DECODE, instret increments.
- Reset asserted in L_MEM → all outputs at reset values next cycle, state FETCH, imem_req = 1.
